// File: rtl/regfile_dump.sv
// ---------------------------------------------------------------------------
// regfile_dump
//
// Sequential debug reader for the 32 x 32-bit register file. A start request
// latches a contiguous (optionally wrapping) range of register indices. The
// block then walks that range, borrowing one register-file read port per
// index, and streams each captured value out over a valid/ready handshake.
// The core stalls while busy is high, because the read port is shared.
//
// Ports:
//   clk        - single clock, rising-edge active
//   reset_n    - synchronous active-low reset
//   start      - request a dump (sampled only in IDLE)
//   first_reg  - first index of the range, latched on start
//   last_reg   - last index of the range, latched on start
//   abort      - cancel an in-progress dump (ignored in IDLE)
//   rd_addr    - read-port index driven into the register file
//   rd_data    - combinational read data for rd_addr
//   busy       - high in READ and SEND; the shared read port is in use
//   out_valid  - out_data / out_index / out_last hold a valid beat
//   out_ready  - consumer accepts the beat
//   out_data   - captured register value
//   out_index  - register index that out_data came from
//   out_last   - current beat is the final index of the range
//   done       - one-cycle pulse after the final beat is accepted
// ---------------------------------------------------------------------------
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] last_q;
    logic [ADDR_W-1:0] next_idx;

    // Index arithmetic wraps modulo NUM_REGS, written out explicitly so the
    // wrap stays correct even if NUM_REGS is not a power of two.
    assign next_idx = (idx == ADDR_W'(NUM_REGS - 1)) ? '0 : idx + 1'b1;

    // Single FSM process. busy, out_valid, done and rd_addr are registered
    // alongside the state so they always match the state being entered and
    // never depend combinationally on out_ready, start or abort.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            last_q    <= '0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_addr   <= '0;
        end else if (abort && state != IDLE) begin
            // Abort wins over the handshake; a beat accepted in this same
            // cycle still counted on the consumer side, but nothing follows.
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_addr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        idx     <= first_reg;
                        last_q  <= last_reg;
                        rd_addr <= first_reg;
                        busy    <= 1'b1;
                        state   <= READ;
                    end
                end
                READ: begin
                    out_data  <= rd_data;
                    out_index <= idx;
                    out_last  <= (idx == last_q);
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            rd_addr <= '0;
                            state   <= DONE;
                        end else begin
                            idx     <= next_idx;
                            rd_addr <= next_idx;
                            state   <= READ;
                        end
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here, so a request
                    // arriving during DONE is dropped rather than queued.
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    rd_addr   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// ---------------------------------------------------------------------------
// tb_regfile_dump
//
// Self-checking bench for regfile_dump. A behavioural register file answers
// the read port; expected beats are derived from the range rules (index
// sequence, beat count, done cycle) and compared against the stream.
// ---------------------------------------------------------------------------
module tb_regfile_dump;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] first_reg;
    logic [ADDR_W-1:0] last_reg;
    logic              abort;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;
    logic              done;

    logic [DATA_W-1:0] regs [NUM_REGS];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int first;
        int last;
        int exp_beats;
        int exp_done;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    // Behavioural register file: combinational read.
    assign rd_data = regs[rd_addr];

    regfile_dump #(
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .first_reg(first_reg),
        .last_reg (last_reg),
        .abort    (abort),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_index(out_index),
        .out_last (out_last),
        .done     (done)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input int f, input int l,
                                 input logic a, input logic r);
        start     = s;
        first_reg = ADDR_W'(f);
        last_reg  = ADDR_W'(l);
        abort     = a;
        out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 0);
        checkOutput({tag, "_busy"},      32'(busy),      0);
        checkOutput({tag, "_done"},      32'(done),      0);
        checkOutput({tag, "_rd_addr"},   32'(rd_addr),   0);
    endtask

    // mode 0: ready always high; 1: random ready; 2: hold ready low for
    // 5 cycles while beat index 3 is valid; 3: ready high and a stray start
    // pulse while a beat is being presented.
    task automatic runDump(input int f, input int l, input int mode,
                           output int beats, output int done_cycle);
        int  exp_idx [$];
        int  count;
        int  stalls;
        int  stall3;
        bit  prev_stall;
        logic [DATA_W-1:0] sv_data;
        logic [ADDR_W-1:0] sv_index;
        logic              sv_last;
        logic r;
        logic poke;
        int  e;

        count = ((l - f + NUM_REGS) % NUM_REGS) + 1;
        for (int k = 0; k < count; k++) exp_idx.push_back((f + k) % NUM_REGS);
        stalls = 0; stall3 = 0; prev_stall = 0; beats = 0; done_cycle = -1;
        sv_data = '0; sv_index = '0; sv_last = 1'b0;

        applyStimulus(1'b1, f, l, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);

        for (int c = 1; c <= 1000; c++) begin
            checkOutput("busy_and_done", 32'(busy & done), 0);
            if (done) begin
                done_cycle = c;
                break;
            end
            r = 1'b1;
            poke = 1'b0;
            if (mode == 1) r = 1'($urandom_range(0, 1));
            if (out_valid) begin
                if (prev_stall) begin
                    checkOutput("stall_data",  out_data,         sv_data);
                    checkOutput("stall_index", 32'(out_index),   32'(sv_index));
                    checkOutput("stall_last",  32'(out_last),    32'(sv_last));
                end
                if (mode == 2 && out_index == 3 && stall3 < 5) begin
                    r = 1'b0;
                    stall3++;
                end
                if (mode == 3) poke = 1'b1;
                if (!r) begin
                    stalls++;
                    prev_stall = 1;
                    sv_data = out_data; sv_index = out_index; sv_last = out_last;
                end else begin
                    prev_stall = 0;
                    if (exp_idx.size() == 0) begin
                        checkOutput("extra_beat", 32'(out_index), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_idx.pop_front();
                        checkOutput("beat_index",   32'(out_index), 32'(e));
                        checkOutput("beat_rd_addr", 32'(rd_addr),   32'(e));
                        checkOutput("beat_data",    out_data,       regs[e]);
                        checkOutput("beat_last",    32'(out_last),
                                    32'(exp_idx.size() == 0));
                        beats++;
                    end
                end
            end
            applyStimulus(poke, 20, 25, 1'b0, r);
            tick();
        end

        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
        if (done_cycle < 0) checkOutput("done_timeout", 0, 1);
        checkOutput("beats_missing", 32'(exp_idx.size()), 0);
        checkOutput("done_cycle", 32'(done_cycle), 32'(2 * count + 1 + stalls));
        tick();
        checkIdle("after_done");
        if (mode == 3) begin
            tick();
            checkIdle("no_second_dump");
        end
    endtask

    // Abort (or reset) while beat 5 of a full dump is waiting with ready low.
    task automatic runAbort(input bit use_reset);
        int  xfers;
        bit  hit;
        int  b;
        int  d;
        xfers = 0; hit = 0;
        applyStimulus(1'b1, 0, 31, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
        for (int c = 1; c <= 200; c++) begin
            if (out_valid && out_index == 5) begin
                if (use_reset) begin
                    reset_n = 1'b0;
                    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
                end else begin
                    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
                end
                tick();
                hit = 1;
                break;
            end
            if (out_valid) begin
                checkOutput("pre_abort_index", 32'(out_index), 32'(xfers));
                xfers++;
            end
            tick();
        end
        if (!hit) checkOutput("abort_point_timeout", 0, 1);
        checkIdle(use_reset ? "reset_mid" : "abort_mid");
        if (use_reset) begin
            checkOutput("reset_mid_out_data",  out_data,        0);
            checkOutput("reset_mid_out_index", 32'(out_index),  0);
            checkOutput("reset_mid_out_last",  32'(out_last),   0);
        end
        checkOutput("pre_abort_beats", 32'(xfers), 5);
        reset_n = 1'b1;
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
        for (int c = 0; c < 6; c++) begin
            tick();
            checkOutput("post_abort_done",  32'(done),      0);
            checkOutput("post_abort_valid", 32'(out_valid), 0);
        end
        runDump(2, 2, 0, b, d);
        checkOutput("clean_beats", 32'(b), 1);
        checkOutput("clean_done",  32'(d), 3);
    endtask

    initial begin
        int b;
        int d;
        int f;
        int l;

        vecs[0] = '{first: 0,  last: 31, exp_beats: 32, exp_done: 65};
        vecs[1] = '{first: 30, last: 1,  exp_beats: 4,  exp_done: 9};
        vecs[2] = '{first: 7,  last: 7,  exp_beats: 1,  exp_done: 3};
        vecs[3] = '{first: 31, last: 0,  exp_beats: 2,  exp_done: 5};
        vecs[4] = '{first: 5,  last: 4,  exp_beats: 32, exp_done: 65};

        for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'(i) * 32'h0101_0101;

        reset_n = 1'b0;
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
        tick();
        tick();
        checkIdle("reset");
        checkOutput("reset_out_data",  out_data,       0);
        checkOutput("reset_out_index", 32'(out_index), 0);
        checkOutput("reset_out_last",  32'(out_last),  0);
        reset_n = 1'b1;
        tick();
        checkIdle("reset_release");

        // Idle: abort and toggling ready with no start do nothing.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 3, 9, 1'b1, 1'(i % 2));
            tick();
            checkIdle("idle");
        end
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);

        $display("[TB] table-driven ranges");
        for (int i = 0; i < 5; i++) begin
            runDump(vecs[i].first, vecs[i].last, 0, b, d);
            checkOutput("tbl_beats", 32'(b), 32'(vecs[i].exp_beats));
            checkOutput("tbl_done",  32'(d), 32'(vecs[i].exp_done));
        end

        $display("[TB] back-pressure on beat 3");
        runDump(0, 31, 2, b, d);
        checkOutput("bp_beats", 32'(b), 32);
        checkOutput("bp_done",  32'(d), 70);

        $display("[TB] single beat with stray start");
        runDump(7, 7, 3, b, d);
        checkOutput("single_beats", 32'(b), 1);
        checkOutput("single_done",  32'(d), 3);

        $display("[TB] abort and reset mid-dump");
        runAbort(1'b0);
        runAbort(1'b1);

        $display("[TB] randomized dumps");
        for (int i = 1; i < NUM_REGS; i++) regs[i] = $urandom;
        regs[0] = '0;
        for (int i = 0; i < 8; i++) begin
            f = int'($urandom_range(0, NUM_REGS - 1));
            l = int'($urandom_range(0, NUM_REGS - 1));
            runDump(f, l, 1, b, d);
            checkOutput("rnd_beats", 32'(b), 32'(((l - f + NUM_REGS) % NUM_REGS) + 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
